// File: rtl/bfly10_stage.sv
// Radix-2 butterfly ahead of twd_mul10: buffers HALF_BLK beats, then emits buf+in / buf-in per lane. Optional BFLY10_SAT_EN saturates and adds sat_flag.
// Latency: outputs are registered one cycle after each accepted EMIT beat. No backpressure: every din_valid beat is taken.
module bfly10_stage #(
  parameter int WIDTH    = 12,
  parameter int LANES    = 16,
  parameter int HALF_BLK = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din_valid,
  input  logic signed [WIDTH-1:0] din_re       [LANES],
  input  logic signed [WIDTH-1:0] din_im       [LANES],
  output logic                    dout_valid,
  output logic signed [WIDTH-1:0] dout_sum_re  [LANES],
  output logic signed [WIDTH-1:0] dout_sum_im  [LANES],
  output logic signed [WIDTH-1:0] dout_diff_re [LANES],
  output logic signed [WIDTH-1:0] dout_diff_im [LANES],
  output logic                    dout_last,
  output logic                    busy
`ifdef BFLY10_SAT_EN
  ,
  output logic                    sat_flag
`endif
);

  localparam int CNT_W = (HALF_BLK > 1) ? $clog2(HALF_BLK) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(HALF_BLK - 1);

  typedef enum logic {FILL, EMIT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               fill_we, emit_go, last_go;

  logic signed [WIDTH-1:0] hold_re [HALF_BLK][LANES];
  logic signed [WIDTH-1:0] hold_im [HALF_BLK][LANES];

  logic signed [WIDTH:0]   sum_re_w  [LANES];
  logic signed [WIDTH:0]   sum_im_w  [LANES];
  logic signed [WIDTH:0]   diff_re_w [LANES];
  logic signed [WIDTH:0]   diff_im_w [LANES];
  logic signed [WIDTH-1:0] sum_re_r  [LANES];
  logic signed [WIDTH-1:0] sum_im_r  [LANES];
  logic signed [WIDTH-1:0] diff_re_r [LANES];
  logic signed [WIDTH-1:0] diff_im_r [LANES];

  function automatic logic signed [WIDTH-1:0] reduce(input logic signed [WIDTH:0] v);
`ifdef BFLY10_SAT_EN
    if (v[WIDTH] != v[WIDTH-1])
      return v[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return v[WIDTH-1:0];
`else
    return WIDTH'(v);
`endif
  endfunction

  // Beat counter tracks pairing position and only moves on valid beats.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    fill_we    = 1'b0;
    emit_go    = 1'b0;
    last_go    = 1'b0;
    if (din_valid) begin
      case (state_q)
        FILL: begin
          fill_we = 1'b1;
          if (beat_cnt_q == LAST_IDX) begin
            beat_cnt_d = '0;
            state_d    = EMIT;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
        EMIT: begin
          emit_go = 1'b1;
          if (beat_cnt_q == LAST_IDX) begin
            last_go    = 1'b1;
            beat_cnt_d = '0;
            state_d    = FILL;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      sum_re_w[k]  = (WIDTH+1)'(hold_re[beat_cnt_q][k]) + (WIDTH+1)'(din_re[k]);
      sum_im_w[k]  = (WIDTH+1)'(hold_im[beat_cnt_q][k]) + (WIDTH+1)'(din_im[k]);
      diff_re_w[k] = (WIDTH+1)'(hold_re[beat_cnt_q][k]) - (WIDTH+1)'(din_re[k]);
      diff_im_w[k] = (WIDTH+1)'(hold_im[beat_cnt_q][k]) - (WIDTH+1)'(din_im[k]);
      sum_re_r[k]  = reduce(sum_re_w[k]);
      sum_im_r[k]  = reduce(sum_im_w[k]);
      diff_re_r[k] = reduce(diff_re_w[k]);
      diff_im_r[k] = reduce(diff_im_w[k]);
    end
  end

`ifdef BFLY10_SAT_EN
  logic sat_hit;
  always_comb begin
    sat_hit = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      sat_hit = sat_hit
              | (sum_re_w[k][WIDTH]  ^ sum_re_w[k][WIDTH-1])
              | (sum_im_w[k][WIDTH]  ^ sum_im_w[k][WIDTH-1])
              | (diff_re_w[k][WIDTH] ^ diff_re_w[k][WIDTH-1])
              | (diff_im_w[k][WIDTH] ^ diff_im_w[k][WIDTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      sat_flag <= 1'b0;
    else if (emit_go && sat_hit)
      sat_flag <= 1'b1;
  end
`endif

  // Buffer contents are don't-care after reset, so no reset term on the storage.
  always_ff @(posedge clk) begin
    if (fill_we && !rst) begin
      for (int k = 0; k < LANES; k++) begin
        hold_re[beat_cnt_q][k] <= din_re[k];
        hold_im[beat_cnt_q][k] <= din_im[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      beat_cnt_q <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      busy       <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        dout_sum_re[k]  <= '0;
        dout_sum_im[k]  <= '0;
        dout_diff_re[k] <= '0;
        dout_diff_im[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      dout_valid <= emit_go;
      dout_last  <= last_go;
      busy       <= (state_d == EMIT) || (beat_cnt_d != '0);
      if (emit_go) begin
        for (int k = 0; k < LANES; k++) begin
          dout_sum_re[k]  <= sum_re_r[k];
          dout_sum_im[k]  <= sum_im_r[k];
          dout_diff_re[k] <= diff_re_r[k];
          dout_diff_im[k] <= diff_im_r[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_bfly10_stage.sv
// Directed-vector bench for bfly10_stage (WIDTH=12, LANES=16, HALF_BLK=2); follows BFLY10_SAT_EN if defined.
module tb_bfly10_stage;

  localparam int W = 12;
  localparam int L = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              din_valid = 1'b0;
  logic signed [W-1:0] din_re [L];
  logic signed [W-1:0] din_im [L];
  logic              dout_valid;
  logic signed [W-1:0] dout_sum_re [L];
  logic signed [W-1:0] dout_sum_im [L];
  logic signed [W-1:0] dout_diff_re [L];
  logic signed [W-1:0] dout_diff_im [L];
  logic              dout_last;
  logic              busy;
`ifdef BFLY10_SAT_EN
  logic              sat_flag;
`endif

  int checks = 0;
  int errors = 0;

  bfly10_stage #(.WIDTH(W), .LANES(L), .HALF_BLK(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .din_valid    (din_valid),
    .din_re       (din_re),
    .din_im       (din_im),
    .dout_valid   (dout_valid),
    .dout_sum_re  (dout_sum_re),
    .dout_sum_im  (dout_sum_im),
    .dout_diff_re (dout_diff_re),
    .dout_diff_im (dout_diff_im),
    .dout_last    (dout_last),
    .busy         (busy)
`ifdef BFLY10_SAT_EN
    ,
    .sat_flag     (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  // Advance one edge and land 1 time unit after it, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int re, input int im, input logic v);
    for (int k = 0; k < L; k++) begin
      din_re[k] = W'(re);
      din_im[k] = W'(im);
    end
    din_valid = v;
  endtask

  task automatic pulse_reset();
    drive(0, 0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive(55, -55, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(0, 0, 1'b0);
    checks++;
    if (dout_valid !== 1'b0 || dout_last !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl valid=%b last=%b busy=%b want 0,0,0", dout_valid, dout_last, busy);
    end
    for (int k = 0; k < L; k++) begin
      checks++;
      if (dout_sum_re[k] !== '0 || dout_sum_im[k] !== '0 || dout_diff_re[k] !== '0 || dout_diff_im[k] !== '0) begin
        errors++;
        $display("FAIL reset_lane%0d sum=(%0d,%0d) diff=(%0d,%0d) want zeros", k,
                 dout_sum_re[k], dout_sum_im[k], dout_diff_re[k], dout_diff_im[k]);
      end
    end
`ifdef BFLY10_SAT_EN
    checks++;
    if (sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_sat_flag got %b want 0", sat_flag);
    end
`endif
  endtask

  task automatic test_basic_pair();
    pulse_reset();
    drive(100, -50, 1'b1); step();
    checks++;
    if (dout_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_after_A valid=%b busy=%b want 0,1", dout_valid, busy);
    end
    drive(7, 3, 1'b1); step();
    drive(30, 20, 1'b1); step();
    for (int k = 0; k < L; k += 15) begin
      checks++;
      if (dout_valid !== 1'b1 || dout_last !== 1'b0 || dout_sum_re[k] !== 12'sd130 || dout_sum_im[k] !== -12'sd30 ||
          dout_diff_re[k] !== 12'sd70 || dout_diff_im[k] !== -12'sd70) begin
        errors++;
        $display("FAIL basic_C lane%0d v=%b l=%b sum=(%0d,%0d) diff=(%0d,%0d) want v1 l0 (130,-30) (70,-70)", k,
                 dout_valid, dout_last, dout_sum_re[k], dout_sum_im[k], dout_diff_re[k], dout_diff_im[k]);
      end
    end
    drive(-7, -3, 1'b1); step();
    for (int k = 0; k < L; k += 15) begin
      checks++;
      if (dout_valid !== 1'b1 || dout_last !== 1'b1 || dout_sum_re[k] !== 12'sd0 || dout_sum_im[k] !== 12'sd0 ||
          dout_diff_re[k] !== 12'sd14 || dout_diff_im[k] !== 12'sd6) begin
        errors++;
        $display("FAIL basic_D lane%0d v=%b l=%b sum=(%0d,%0d) diff=(%0d,%0d) want v1 l1 (0,0) (14,6)", k,
                 dout_valid, dout_last, dout_sum_re[k], dout_sum_im[k], dout_diff_re[k], dout_diff_im[k]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_end got %b want 0", busy);
    end
    drive(0, 0, 1'b0); step();
    checks++;
    if (dout_valid !== 1'b0 || dout_last !== 1'b0 || dout_diff_re[0] !== 12'sd14) begin
      errors++;
      $display("FAIL basic_idle v=%b l=%b diff_re=%0d want 0,0,14 held", dout_valid, dout_last, dout_diff_re[0]);
    end
  endtask

  task automatic test_gaps();
    int re_t [4] = '{100, 7, 30, -7};
    int im_t [4] = '{-50, 3, 20, -3};
    int sr_t [4] = '{0, 0, 130, 0};
    int si_t [4] = '{0, 0, -30, 0};
    int dr_t [4] = '{0, 0, 70, 14};
    int di_t [4] = '{0, 0, -70, 6};
    pulse_reset();
    for (int b = 0; b < 4; b++) begin
      drive(re_t[b], im_t[b], 1'b1); step();
      checks++;
      if (b < 2) begin
        if (dout_valid !== 1'b0) begin
          errors++;
          $display("FAIL gaps_fill%0d valid=%b want 0", b, dout_valid);
        end
      end else if (dout_valid !== 1'b1 || dout_last !== (b == 3) ||
                   dout_sum_re[3] !== W'(sr_t[b]) || dout_sum_im[3] !== W'(si_t[b]) ||
                   dout_diff_re[3] !== W'(dr_t[b]) || dout_diff_im[3] !== W'(di_t[b])) begin
        errors++;
        $display("FAIL gaps_emit%0d v=%b l=%b sum=(%0d,%0d) diff=(%0d,%0d) want (%0d,%0d) (%0d,%0d)", b,
                 dout_valid, dout_last, dout_sum_re[3], dout_sum_im[3], dout_diff_re[3], dout_diff_im[3],
                 sr_t[b], si_t[b], dr_t[b], di_t[b]);
      end
      drive(0, 0, 1'b0);
      for (int g = 0; g < 3; g++) begin
        step();
        checks++;
        if (dout_valid !== 1'b0 || dout_last !== 1'b0) begin
          errors++;
          $display("FAIL gaps_idle b%0d g%0d valid=%b last=%b want 0,0", b, g, dout_valid, dout_last);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int exp_sum;
    int exp_diff;
`ifdef BFLY10_SAT_EN
    exp_sum  = 2047;
    exp_diff = -2048;
`else
    exp_sum  = -1996;
    exp_diff = 1996;
`endif
    pulse_reset();
    drive(2000, 0, 1'b1); step();
    drive(-2000, 0, 1'b1); step();
    drive(100, 0, 1'b1); step();
    checks++;
    if (dout_valid !== 1'b1 || dout_sum_re[0] !== W'(exp_sum) || dout_diff_re[0] !== 12'sd1900) begin
      errors++;
      $display("FAIL ovf_sum v=%b sum_re=%0d diff_re=%0d want 1,%0d,1900", dout_valid, dout_sum_re[0], dout_diff_re[0], exp_sum);
    end
`ifdef BFLY10_SAT_EN
    checks++;
    if (sat_flag !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sat_flag got %b want 1", sat_flag);
    end
`endif
    drive(100, 0, 1'b1); step();
    drive(0, 0, 1'b0);
    checks++;
    if (dout_valid !== 1'b1 || dout_diff_re[0] !== W'(exp_diff) || dout_sum_re[0] !== -12'sd1900) begin
      errors++;
      $display("FAIL ovf_diff v=%b diff_re=%0d sum_re=%0d want 1,%0d,-1900", dout_valid, dout_diff_re[0], dout_sum_re[0], exp_diff);
    end
  endtask

  task automatic test_reset_mid_block();
    pulse_reset();
    drive(500, 500, 1'b1); step();
    drive(600, 600, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after busy=%b valid=%b want 0,0", busy, dout_valid);
    end
    drive(10, 20, 1'b1); step();
    drive(-5, 5, 1'b1); step();
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_C_buffered valid=%b want 0", dout_valid);
    end
    drive(1, 2, 1'b1); step();
    checks++;
    if (dout_valid !== 1'b1 || dout_last !== 1'b0 || dout_sum_re[5] !== 12'sd11 || dout_sum_im[5] !== 12'sd22 ||
        dout_diff_re[5] !== 12'sd9 || dout_diff_im[5] !== 12'sd18) begin
      errors++;
      $display("FAIL rstmid_D v=%b l=%b sum=(%0d,%0d) diff=(%0d,%0d) want v1 l0 (11,22) (9,18)",
               dout_valid, dout_last, dout_sum_re[5], dout_sum_im[5], dout_diff_re[5], dout_diff_im[5]);
    end
    drive(3, -4, 1'b1); step();
    drive(0, 0, 1'b0);
    checks++;
    if (dout_valid !== 1'b1 || dout_last !== 1'b1 || dout_sum_re[5] !== -12'sd2 || dout_sum_im[5] !== 12'sd1 ||
        dout_diff_re[5] !== -12'sd8 || dout_diff_im[5] !== 12'sd9) begin
      errors++;
      $display("FAIL rstmid_E v=%b l=%b sum=(%0d,%0d) diff=(%0d,%0d) want v1 l1 (-2,1) (-8,9)",
               dout_valid, dout_last, dout_sum_re[5], dout_sum_im[5], dout_diff_re[5], dout_diff_im[5]);
    end
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    for (int i = 0; i < 12; i++) begin
      drive(3 * i, -i, 1'b1); step();
      checks++;
      if (dout_valid !== ((i % 4) >= 2) || dout_last !== ((i % 4) == 3)) begin
        errors++;
        $display("FAIL b2b_cyc%0d valid=%b last=%b want %0d,%0d", i, dout_valid, dout_last, (i % 4) >= 2, (i % 4) == 3);
      end
      if ((i % 4) >= 2) begin
        checks++;
        if (dout_sum_re[9] !== W'(6 * i - 6) || dout_sum_im[9] !== W'(2 - 2 * i) || dout_diff_re[9] !== -12'sd6) begin
          errors++;
          $display("FAIL b2b_data%0d sum=(%0d,%0d) diff_re=%0d want (%0d,%0d) -6", i,
                   dout_sum_re[9], dout_sum_im[9], dout_diff_re[9], 6 * i - 6, 2 - 2 * i);
        end
      end
    end
    drive(0, 0, 1'b0); step();
    checks++;
    if (dout_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_tail valid=%b busy=%b want 0,0", dout_valid, busy);
    end
  endtask

  task automatic test_lane_independence();
    pulse_reset();
    for (int k = 0; k < L; k++) begin
      din_re[k] = W'(k);
      din_im[k] = W'(k);
    end
    din_valid = 1'b1;
    step();
    drive(0, 0, 1'b1); step();
    for (int k = 0; k < L; k++) begin
      din_re[k] = W'(-k);
      din_im[k] = W'(-k);
    end
    step();
    drive(0, 0, 1'b0);
    for (int k = 0; k < L; k++) begin
      checks++;
      if (dout_valid !== 1'b1 || dout_sum_re[k] !== '0 || dout_sum_im[k] !== '0 ||
          dout_diff_re[k] !== W'(2 * k) || dout_diff_im[k] !== W'(2 * k)) begin
        errors++;
        $display("FAIL lane%0d v=%b sum=(%0d,%0d) diff=(%0d,%0d) want (0,0) (%0d,%0d)", k, dout_valid,
                 dout_sum_re[k], dout_sum_im[k], dout_diff_re[k], dout_diff_im[k], 2 * k, 2 * k);
      end
    end
  endtask

  initial begin
    drive(0, 0, 1'b0);
    test_reset();
    test_basic_pair();
    test_gaps();
    test_overflow();
    test_reset_mid_block();
    test_back_to_back();
    test_lane_independence();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
